carry_bypass_mw_add_ctrl: RTL
=============================

Name: carry_bypass_mw_add_ctrl

Overview:
- Sequencer for multi-word add and subtract on one shared 8-bit carry-bypass adder slice.
- Operands are WORDS bytes wide. The block processes one byte per cycle, least significant byte first, and keeps the carry in a register between bytes.
- Valid/ready handshakes on both the operand side and the result side.
- Sits between the arithmetic-unit front end and the 8-bit adder datapath, so wide arithmetic does not need a wide adder.

Parameters:
- WORDS, 4, number of 8-bit slices per operand (minimum 1). Operand width W = 8*WORDS.
- CNT_W, $clog2(WORDS)+1, width of the slice counter (derived; do not override).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  operand request.
- in_ready  output  1  block can accept a request.
- in_a  input  W  operand A.
- in_b  input  W  operand B.
- in_cin  input  1  carry-in for add; ignored for subtract.
- in_sub  input  1  0 = A+B+cin, 1 = A-B.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  W  result.
- out_cout  output  1  final carry-out (for subtract: 1 = no borrow).
- out_ovf  output  1  signed two's-complement overflow.

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_sum=0, out_cout=0, out_ovf=0, slice counter=0, carry register=0.
- Reset asserted in any state aborts the operation on the next edge. No partial result is ever presented.
- States and transitions:
  - IDLE: in_ready=1. On in_valid&in_ready, capture A, B, sub. Set carry register = sub ? 1 : in_cin. Counter=0. Go to RUN.
  - RUN: in_ready=0.
    - Each cycle, feed slice k (k = counter) to the 8-bit adder: a = A[8k+:8], b = sub ? ~B[8k+:8] : B[8k+:8], carry-in = carry register.
    - Write the sum byte into result byte k. Carry register <= slice carry-out. Counter increments.
    - After the slice with k=WORDS-1, go to DONE.
    - out_cout <= final carry.
    - out_ovf <= carry into bit W-1 XOR carry out of bit W-1. Compute it as (a[7]^b_eff[7]^s[7]) ^ cout of the top slice.
  - DONE: out_valid=1, out_sum/out_cout/out_ovf stable. Stay until out_ready=1, then go to IDLE.
- Latency: request accepted at edge T, out_valid high from edge T+WORDS, for WORDS+1 cycles per operation at minimum.
- Throughput: one operation per WORDS+2 cycles with out_ready held at 1.
- in_ready is asserted only in IDLE. It is never asserted in the same cycle as out_valid, so there is no accept/complete overlap.
- in_valid while not IDLE has no effect. The requester must hold operands until accepted; the block captures them at acceptance, so later input changes are ignored.
- out_ready while not in DONE is ignored.
- Outputs stay stable while out_valid=1 and out_ready=0 (backpressure of any length).
- Arithmetic is modulo 2^W. For subtract, in_cin has no effect.
- WORDS=1: RUN lasts exactly one cycle. The counter must not wrap or index out of range.
- Counter wrap: the RUN→DONE decision compares against WORDS-1. The counter is cleared on entry to RUN.

Decomposition:
- Shared package carry_bypass_pkg:
  - state enum (IDLE, RUN, DONE).
  - localparam SLICE_W=8.
- Sub-module: the existing 8-bit carry-bypass adder (carry_bypass_adder8: a, b, cin → sum, cout), instantiated once as the shared datapath.
- Slice muxing, the B inversion, the carry register and the result assembly live in this block.

Test Plan:
- WORDS=4, add A=0xFFFFFFFF, B=0x00000001, cin=0 → out_sum=0x00000000, cout=1, ovf=0; out_valid exactly 4 cycles after the accept edge.
- Subtract A=0x80000000, B=0x00000001 → out_sum=0x7FFFFFFF, cout=1, ovf=1. Subtract A=0x00000000, B=0x00000001 → 0xFFFFFFFF, cout=0, ovf=0.
- Add A=0x7FFFFFFF, B=0, cin=1 → 0x80000000, cout=0, ovf=1. Then hold out_ready=0 for 5 cycles → outputs stable, in_ready=0 throughout, in_valid pulses ignored.
- Back-to-back: in_valid=1 and out_ready=1 held, with 3 queued requests → each completes in 6 cycles, results in order, no request accepted while out_valid=1.
- Assert rst for one cycle during the 2nd RUN slice → next cycle IDLE, in_ready=1, out_valid=0. A fresh request then yields a correct result with no carry leakage from the aborted operation.
- WORDS=1 build: add 0xFF+0x01, cin=1 → sum=0x01, cout=1, out_valid one cycle after accept.

Source files
------------

// File: rtl/carry_bypass_pkg.sv
// Shared types for the multi-word carry-bypass add/sub sequencer.
// State encoding and the adder slice width.
package carry_bypass_pkg;

  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/carry_bypass_adder8.sv
// 8-bit carry-bypass adder: two 4-bit ripple blocks, each with
// a bypass path that forwards the block carry-in when all bits propagate.
module carry_bypass_adder8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic c;
  logic cb;
  logic cr;
  logic p;

  // Ripple inside each block, skip the block when it fully propagates.
  always_comb begin
    sum = '0;
    c   = cin;
    cb  = 1'b0;
    cr  = 1'b0;
    p   = 1'b0;
    for (int blk = 0; blk < 2; blk++) begin
      cb = c;
      cr = c;
      for (int i = 0; i < 4; i++) begin
        sum[4*blk+i] = a[4*blk+i] ^ b[4*blk+i] ^ cr;
        cr = (a[4*blk+i] & b[4*blk+i])
           | (cr & (a[4*blk+i] ^ b[4*blk+i]));
      end
      p = &(a[4*blk+:4] ^ b[4*blk+:4]);
      c = p ? cb : cr;
    end
    cout = c;
  end

endmodule

// File: rtl/carry_bypass_mw_add_ctrl.sv
// Multi-word add/sub sequencer on one shared 8-bit adder slice.
// One byte per cycle, LSB first, carry held in a register between bytes.
module carry_bypass_mw_add_ctrl
  import carry_bypass_pkg::*;
#(
  parameter int WORDS = 4,
  parameter int CNT_W = $clog2(WORDS) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SLICE_W*WORDS-1:0] in_a,
  input  logic [SLICE_W*WORDS-1:0] in_b,
  input  logic                     in_cin,
  input  logic                     in_sub,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SLICE_W*WORDS-1:0] out_sum,
  output logic                     out_cout,
  output logic                     out_ovf
);

  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_e state_q, state_d;

  logic [WORDS-1:0][SLICE_W-1:0] a_q, a_d;
  logic [WORDS-1:0][SLICE_W-1:0] b_q, b_d;
  logic [WORDS-1:0][SLICE_W-1:0] sum_q, sum_d;
  logic                          sub_q, sub_d;
  logic                          c_q, c_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          cout_q, cout_d;
  logic                          ovf_q, ovf_d;

  logic [IDX_W-1:0]   idx;
  logic [SLICE_W-1:0] sl_a;
  logic [SLICE_W-1:0] sl_b;
  logic [SLICE_W-1:0] sl_s;
  logic               sl_c;
  logic               last;

  // Slice index is forced to 0 outside RUN so it never leaves the array.
  always_comb begin
    idx  = (state_q == RUN) ? cnt_q[IDX_W-1:0] : '0;
    sl_a = a_q[idx];
    sl_b = sub_q ? ~b_q[idx] : b_q[idx];
    last = (cnt_q == CNT_W'(WORDS - 1));
  end

  carry_bypass_adder8 u_add (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (c_q),
    .sum  (sl_s),
    .cout (sl_c)
  );

  // Next-state and datapath update for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    sub_d   = sub_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          sub_d   = in_sub;
          c_d     = in_sub | in_cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx] = sl_s;
        c_d        = sl_c;
        cnt_d      = cnt_q + CNT_W'(1);
        if (last) begin
          cout_d  = sl_c;
          ovf_d   = sl_a[7] ^ sl_b[7] ^ sl_s[7] ^ sl_c;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Operand, carry, counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      sub_q  <= 1'b0;
      c_q    <= 1'b0;
      cnt_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      sum_q  <= sum_d;
      sub_q  <= sub_d;
      c_q    <= c_d;
      cnt_q  <= cnt_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

endmodule
